// File: rtl/gat_feat_argmax_reader.sv
// Walks each node's final-layer features through BRAM port B and streams one
// signed argmax result per node on a valid/ready interface.
module gat_feat_argmax_reader #(
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NUM_FEATURE_FINAL  = 7,
  parameter int NUM_SUBGRAPHS      = 2708,
  parameter int BRAM_LATENCY       = 2,
  parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_FINAL,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int CLASS_W            = $clog2(NUM_FEATURE_FINAL),
  parameter int NODE_W             = $clog2(NUM_SUBGRAPHS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          gat_ready,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [CLASS_W-1:0]            res_class,
  output logic [NEW_FEATURE_WIDTH-1:0]  res_max,
  output logic [NODE_W-1:0]             res_node,
  output logic                          res_last,
  output logic                          busy,
  output logic                          done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, EMIT} state_t;

  localparam logic [CLASS_W-1:0] K_LAST    = CLASS_W'(NUM_FEATURE_FINAL - 1);
  localparam logic [NODE_W-1:0]  NODE_LAST = NODE_W'(NUM_SUBGRAPHS - 1);

  state_t                                 state, state_nxt;
  logic                                   gat_ready_q;
  logic [CLASS_W-1:0]                     k;
  logic [NODE_W-1:0]                      node;
  logic [NEW_FEATURE_ADDR_W-1:0]          word;
  logic [BRAM_LATENCY-1:0]                vld_pipe;
  logic [BRAM_LATENCY-1:0][CLASS_W-1:0]   tag_pipe;
  logic [NEW_FEATURE_WIDTH-1:0]           max_q;
  logic [CLASS_W-1:0]                     cls_q;

  logic start, ret_vld, ret_last, is_last_node, accept;
  logic [CLASS_W-1:0] ret_tag;

  assign start        = gat_ready & ~gat_ready_q;
  assign ret_vld      = vld_pipe[BRAM_LATENCY-1];
  assign ret_tag      = tag_pipe[BRAM_LATENCY-1];
  assign ret_last     = ret_vld && (ret_tag == K_LAST);
  assign is_last_node = (node == NODE_LAST);
  assign accept       = (state == EMIT) && res_ready;

  // The running word counter is the registered address; no multiplier needed.
  assign feat_bram_addrb = {word, 2'b00};
  assign res_class       = cls_q;
  assign res_max         = max_q;
  assign res_node        = node;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    if (k == K_LAST) state_nxt = DRAIN;
      DRAIN:   if (ret_last) state_nxt = EMIT;
      EMIT:    if (res_ready) state_nxt = is_last_node ? IDLE : READ;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    res_valid = (state == EMIT);
    res_last  = (state == EMIT) && is_last_node;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gat_ready_q <= 1'b1;
      k           <= '0;
      node        <= '0;
      word        <= '0;
      vld_pipe    <= '0;
      tag_pipe    <= '0;
      max_q       <= '0;
      cls_q       <= '0;
      done        <= 1'b0;
    end else begin
      gat_ready_q <= gat_ready;
      done        <= accept && is_last_node;

      case (state)
        IDLE: if (start) begin
          k    <= '0;
          node <= '0;
          word <= '0;
        end
        READ: if (k != K_LAST) begin
          k    <= k + 1'b1;
          word <= word + 1'b1;
        end
        EMIT: if (res_ready && !is_last_node) begin
          node <= node + 1'b1;
          k    <= '0;
          word <= word + 1'b1;
        end
        default: ;
      endcase

      // Tag each issued read with its feature index so it lines up with dout.
      vld_pipe[0] <= (state == READ);
      tag_pipe[0] <= k;
      for (int i = 1; i < BRAM_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end

      if (ret_vld) begin
        if (ret_tag == '0) begin
          max_q <= feat_bram_dout;
          cls_q <= '0;
        end else if ($signed(feat_bram_dout) > $signed(max_q)) begin
          max_q <= feat_bram_dout;
          cls_q <= ret_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_gat_feat_argmax_reader.sv
// Directed bench: one instance at BRAM latency 2, one at latency 1, sharing
// a small feature memory of 3 nodes x 7 classes.
module tb_gat_feat_argmax_reader;

  localparam int F  = 7;
  localparam int NS = 3;

  logic clk = 1'b0;
  logic rst, gat_ready, rr2;
  always #5 clk = ~clk;

  logic [6:0]  addrb2, addrb1;
  logic [31:0] dout2, dout1, max2, max1;
  logic [2:0]  cls2, cls1;
  logic [1:0]  node2, node1;
  logic        valid2, valid1, last2, last1, busy2, busy1, done2, done1;

  logic [31:0] mem [0:F*NS-1];
  logic [31:0] d2a, d2b, d1a;

  always @(posedge clk) begin
    d2a <= mem[addrb2[6:2]];
    d2b <= d2a;
    d1a <= mem[addrb1[6:2]];
  end
  assign dout2 = d2b;
  assign dout1 = d1a;

  gat_feat_argmax_reader #(.NUM_FEATURE_FINAL(F), .NUM_SUBGRAPHS(NS), .BRAM_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .gat_ready(gat_ready), .feat_bram_addrb(addrb2),
    .feat_bram_dout(dout2), .res_valid(valid2), .res_ready(rr2), .res_class(cls2),
    .res_max(max2), .res_node(node2), .res_last(last2), .busy(busy2), .done(done2));

  gat_feat_argmax_reader #(.NUM_FEATURE_FINAL(F), .NUM_SUBGRAPHS(NS), .BRAM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .gat_ready(gat_ready), .feat_bram_addrb(addrb1),
    .feat_bram_dout(dout1), .res_valid(valid1), .res_ready(1'b1), .res_class(cls1),
    .res_max(max1), .res_node(node1), .res_last(last1), .busy(busy1), .done(done1));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int vc2[4], vc1[4];
  logic [31:0] mx2[4], mx1[4];
  logic [2:0]  cl2[4], cl1[4];
  logic [1:0]  nd2[4], nd1[4];
  logic        ls2[4], ls1[4];
  int nv2, nv1, dn2, dn1, dc2, dc1;
  logic bz2, bz1;

  initial begin
    rst = 1'b1; gat_ready = 1'b1; rr2 = 1'b1;
    for (int n = 0; n < NS; n++)
      for (int k = 0; k < F; k++)
        mem[n*F+k] = 32'(k*10 - n);
    repeat (3) @(negedge clk);

    check("rst_valid", valid2, 0);
    check("rst_busy",  busy2, 0);
    check("rst_done",  done2, 0);
    check("rst_last",  last2, 0);
    check("rst_addrb", addrb2, 0);
    check("rst_class", cls2, 0);
    check("rst_max",   max2, 0);
    check("rst_node",  node2, 0);
    rst = 1'b0;

    // Level already high at reset release must not start a readout.
    repeat (5) @(negedge clk);
    check("hi_at_rst_busy2", busy2, 0);
    check("hi_at_rst_busy1", busy1, 0);
    gat_ready = 1'b0;
    @(negedge clk);

    // Basic run, res_ready high.
    nv2 = 0; nv1 = 0; dn2 = 0; dn1 = 0; dc2 = 0; dc1 = 0; bz2 = 1'b1; bz1 = 1'b1;
    gat_ready = 1'b1;
    for (int n = 1; n <= 34; n++) begin
      @(negedge clk);
      if (n == 1)  begin check("start_addrb", addrb2, 0); check("start_busy", busy2, 1); end
      if (n == 7)  check("addrb_k6", addrb2, 24);
      if (n == 11) check("addrb_node1", addrb2, 28);
      if (valid2 && nv2 < 4) begin
        vc2[nv2] = n; cl2[nv2] = cls2; mx2[nv2] = max2; nd2[nv2] = node2; ls2[nv2] = last2; nv2++;
      end
      if (valid1 && nv1 < 4) begin
        vc1[nv1] = n; cl1[nv1] = cls1; mx1[nv1] = max1; nd1[nv1] = node1; ls1[nv1] = last1; nv1++;
      end
      if (done2) begin dn2++; dc2 = n; bz2 = busy2; end
      if (done1) begin dn1++; dc1 = n; bz1 = busy1; end
    end
    check("l2_results", nv2, 3);
    check("l1_results", nv1, 3);
    for (int i = 0; i < 3; i++) begin
      check("l2_cycle", vc2[i], 10 + 10*i);
      check("l2_class", cl2[i], 6);
      check("l2_max",   mx2[i], 60 - i);
      check("l2_node",  nd2[i], i);
      check("l2_last",  ls2[i], (i == 2) ? 1 : 0);
      check("l1_cycle", vc1[i], 9 + 9*i);
      check("l1_class", cl1[i], 6);
      check("l1_max",   mx1[i], 60 - i);
      check("l1_node",  nd1[i], i);
      check("l1_last",  ls1[i], (i == 2) ? 1 : 0);
    end
    check("l2_done_cnt", dn2, 1);
    check("l2_done_cyc", dc2, 31);
    check("l2_busy_at_done", bz2, 0);
    check("l1_done_cnt", dn1, 1);
    check("l1_done_cyc", dc1, 28);
    check("l1_busy_at_done", bz1, 0);

    // Signed/tie data on node 1, plus 20 cycles of backpressure on node 0.
    gat_ready = 1'b0;
    mem[7] = 32'hFFFF_FFFB; mem[8]  = 32'hFFFF_FFFF; mem[9]  = 32'hFFFF_FFFF;
    mem[10] = 32'hFFFF_FFF8; mem[11] = 32'hFFFF_FFFE; mem[12] = 32'hFFFF_FFFF;
    mem[13] = 32'hFFFF_FFFD;
    rr2 = 1'b0;
    @(negedge clk);
    gat_ready = 1'b1;
    for (int n = 1; n <= 52; n++) begin
      @(negedge clk);
      if (n >= 10 && n <= 29) begin
        check("bp_valid", valid2, 1);
        check("bp_addrb", addrb2, 24);
        check("bp_max",   max2, 60);
        check("bp_class", cls2, 6);
        check("bp_node",  node2, 0);
      end
      if (n == 18) begin check("l1_tie_class", cls1, 1); check("l1_tie_max", max1, 32'hFFFF_FFFF); end
      if (n == 30) begin
        check("release_addrb", addrb2, 28);
        check("release_valid", valid2, 0);
        check("release_busy", busy2, 1);
      end
      if (n == 39) begin
        check("tie_valid", valid2, 1);
        check("tie_node",  node2, 1);
        check("tie_class", cls2, 1);
        check("tie_max",   max2, 32'hFFFF_FFFF);
      end
      if (n == 49) begin
        check("bp_last_node", node2, 2);
        check("bp_last_flag", last2, 1);
        check("bp_last_max",  max2, 58);
      end
      if (n == 50) begin check("bp_done", done2, 1); check("bp_busy_off", busy2, 0); end
      if (n == 15) gat_ready = 1'b0;
      if (n == 16) gat_ready = 1'b1;
      if (n == 29) rr2 = 1'b1;
    end

    // Fresh edge after done reruns from address 0; reset it during node 1 READ.
    gat_ready = 1'b0;
    @(negedge clk);
    gat_ready = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      if (n == 1)  begin check("rerun_addrb", addrb2, 0); check("rerun_busy", busy2, 1); end
      if (n == 10) begin check("rerun_valid", valid2, 1); check("rerun_max", max2, 60); end
      if (n == 13) check("pre_rst_addrb", addrb2, 36);
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy2",  busy2, 0);
    check("midrst_valid2", valid2, 0);
    check("midrst_busy1",  busy1, 0);
    check("midrst_node2",  node2, 0);
    rst = 1'b0;
    gat_ready = 1'b0;
    @(negedge clk);
    gat_ready = 1'b1;
    dn2 = 0;
    for (int n = 1; n <= 31; n++) begin
      @(negedge clk);
      if (n == 1)  check("restart_addrb", addrb2, 0);
      if (n == 10) begin
        check("restart_node",  node2, 0);
        check("restart_class", cls2, 6);
        check("restart_max",   max2, 60);
      end
      if (done2) dn2++;
      if (n == 31) check("restart_done_now", done2, 1);
    end
    check("restart_done_cnt", dn2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
